write_back: RTL and testbench
=============================

# write_back

Final pipeline stage of the Kasumi RV32I core, directly downstream of the MEM stage. It owns the 32×32 integer register file and the machine-mode CSR file, and it commits register and CSR writebacks. It handles trap entry and `mret`, and it maintains the 64-bit `mcycle`/`minstret` counters. It serves combinational register-read ports to decode and CSR-read ports back to MEM.

## Interface
Parameters:
- `HART_ID`, 0: value returned by `mhartid`.
- `RESET_MTVEC`, 32'h0000_0000: reset value of `mtvec`.

Ports:
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stop` in 1: pipeline stall; when high, blocks all commits except the `mcycle` increment.
- `in_reg_d` in 5: destination register; 0 means no register write.
- `in_wb_data` in 32: register writeback value.
- `in_now_pc` in 32: PC of the instruction in WB.
- `in_retire` in 1: a valid instruction occupies WB this cycle.
- `in_wb_csr` in 1: CSR write request.
- `in_csr_addr` in 12: CSR write address.
- `in_csr_data` in 32: CSR write value.
- `in_trap` in 1: trap entry (ecall/ebreak/illegal).
- `in_trap_cause` in 32: value written to `mcause` on trap entry.
- `in_mret` in 1: return from trap.
- `rs1_addr`, `rs2_addr` in 5: register read addresses.
- `rs1_data`, `rs2_data` out 32: register read data (combinational).
- `csr_addr` in 12: CSR read address from MEM.
- `csr_data` out 32: CSR read data (combinational).
- `csr_trap_vec_data` out 32: current `mtvec`.
- `csr_exception_pc_data` out 32: current `mepc`.

## Operation
- Commit enable `ce = in_retire & ~stop & ~rst`.
- Register write: on `ce & ~in_trap & (in_reg_d != 0)`, set `x[in_reg_d] <= in_wb_data`. `x0` is never written.
- CSR write: on `ce & ~in_trap & in_wb_csr`.
  - Unknown or read-only addresses: write ignored.
- Trap entry on `ce & in_trap`:
  - Sets `mepc <= {in_now_pc[31:2],2'b00}` and `mcause <= in_trap_cause`.
  - Sets `mstatus.MPIE <= MIE` and `MIE <= 0`.
  - Suppresses the register write, the CSR write and `mret`.
- `mret` on `ce & in_mret & ~in_trap`: `MIE <= MPIE`, `MPIE <= 1`.
- CSR map:
  - `mstatus` 0x300: only bits 3 (MIE) and 7 (MPIE) are stored; all other bits read 0.
  - `misa` 0x301: reads 32'h4000_0100; read-only.
  - `mtvec` 0x305: bits [1:0] forced to 0.
  - `mscratch` 0x340: full 32 bits.
  - `mepc` 0x341: bits [1:0] forced to 0.
  - `mcause` 0x342: full 32 bits.
  - `mcycle`/`mcycleh` 0xB00/0xB80 and `minstret`/`minstreth` 0xB02/0xB82: writable.
  - `cycle`, `cycleh`, `instret`, `instreth` 0xC00/0xC80/0xC02/0xC82: read-only aliases of the counters.
  - `mhartid` 0xF14 reads `HART_ID`. Any unlisted address reads 0.
- Counters are 64-bit and wrap from 2^64−1 to 0.
  - `mcycle` increments on every edge with `rst=0`, regardless of `stop`.
  - `minstret` increments on `ce & ~in_trap`.
  - A CSR write to either half wins over that cycle's increment. It replaces that half; the other half holds and no carry is applied that cycle.
- Register read bypass: if `rsN_addr == in_reg_d` and the register write is enabled this cycle, `rsN_data = in_wb_data`. Otherwise it returns the array value. `rsN_addr == 0` always returns 0.
- CSR read bypass: if `csr_addr == in_csr_addr` and the CSR write is enabled, `csr_data` returns the masked value about to be written.
  - Counter reads do not bypass the increment; they return the pre-edge value.
  - `csr_trap_vec_data` and `csr_exception_pc_data` never bypass.

## Timing
- Reset (edge with `rst=1`) sets:
  - all `x1..x31`, `mstatus`, `mscratch`, `mepc`, `mcause`, `mcycle` and `minstret` to 0;
  - `mtvec` to `RESET_MTVEC`.
- Outputs after reset: `rs1_data`, `rs2_data` and `csr_exception_pc_data` read 0; `csr_trap_vec_data` reads `RESET_MTVEC`.
- Reset mid-operation overrides every same-cycle commit, trap or `mret`.
- Write latency: state updates at the edge ending the WB cycle and is visible from the array on the next cycle. Same-cycle visibility comes only through the bypass.
- `mcycle` read in the cycle after the k-th non-reset edge returns k.
- `stop` high for N cycles: there are no commits, `mcycle` advances by N, and all inputs are re-presented after the stall.
- Priority when `in_trap`, `in_mret` and `in_wb_csr` coincide: trap > mret; trap also cancels CSR and register writes.

## Structure
- Package `kasumi_csr_pkg` holds:
  - the CSR address localparams;
  - `MSTATUS_MIE=3` and `MSTATUS_MPIE=7`;
  - `MISA_VALUE`.
- Sub-module `csr_file` contains the CSR storage, counters, trap/mret logic and CSR read mux with bypass.
- `write_back` itself contains the register file, its bypass and the commit-enable logic.

## Test plan
- Reset, then read all of x0..x31 and all CSRs: `mtvec = RESET_MTVEC`, everything else 0, `misa = 32'h4000_0100`.
- Write x5 = 32'hDEAD_BEEF with `rs1_addr = 5` in the same cycle: `rs1_data = 32'hDEAD_BEEF` that cycle. Write to x0: x0 still reads 0.
- `csrw mtvec, 32'h0000_1003`: reads back 32'h0000_1000 and `csr_trap_vec_data = 32'h1000`. Assert `stop` on a second write: no change.
- Set MIE=1, then trap at PC 32'h0000_0404 with cause 11 while x7 and `mscratch` writes are also requested:
  - `mepc = 32'h404`, `mcause = 11`, MIE=0, MPIE=1;
  - x7 and `mscratch` are unchanged;
  - a following `mret` gives MIE=1, MPIE=1.
- Write `mcycle = 32'hFFFF_FFFF` with `mcycleh = 0`, then run 2 idle cycles: `mcycle = 1`, `mcycleh = 1`.
- Retire 3 instructions with a 4-cycle stall between them: `minstret = 3`, and `mcycle` has advanced by all elapsed cycles including the stall.

Source files
------------

// File: rtl/kasumi_csr_pkg.sv
// Machine-mode CSR addresses, mstatus bit positions and the write-side helpers
// shared by the writeback stage and its CSR file.
package kasumi_csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

    function automatic logic csr_is_writable(input logic [11:0] addr);
        logic ok;
        case (addr)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
            CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH: ok = 1'b1;
            default:                                               ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Value a write actually stores, i.e. what a later read returns.
    function automatic logic [31:0] csr_write_mask(input logic [11:0] addr,
                                                   input logic [31:0] data);
        logic [31:0] val;
        val = data;
        case (addr)
            CSR_MSTATUS: begin
                val = '0;
                val[MSTATUS_MIE]  = data[MSTATUS_MIE];
                val[MSTATUS_MPIE] = data[MSTATUS_MPIE];
            end
            CSR_MTVEC, CSR_MEPC: val = {data[31:2], 2'b00};
            default: ;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/csr_file.sv
// Machine-mode CSR storage: mstatus/mtvec/mscratch/mepc/mcause, 64-bit
// cycle and instret counters, trap entry / mret, and the CSR read mux.
module csr_file
    import kasumi_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        trap,
    input  logic        mret,
    input  logic        wb_csr,
    input  logic [11:0] wr_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] now_pc,
    input  logic [31:0] trap_cause,
    input  logic [11:0] rd_addr,
    output logic [31:0] rd_data,
    output logic [31:0] trap_vec,
    output logic [31:0] epc
);

    logic        mie;
    logic        mpie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic        retire_en;
    logic        trap_en;
    logic        mret_en;
    logic        csr_we;
    logic [31:0] wr_val;
    logic [31:0] mstatus_val;
    logic [31:0] rd_val;

    assign trap_en   = ce & trap;
    assign retire_en = ce & ~trap;
    assign mret_en   = retire_en & mret;
    assign csr_we    = retire_en & wb_csr & csr_is_writable(wr_addr);
    assign wr_val    = csr_write_mask(wr_addr, wr_data);

    assign trap_vec  = mtvec;
    assign epc       = mepc;

    // mret is applied after a same-cycle mstatus write, so it wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mtvec    <= RESET_MTVEC;
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
        end else begin
            if (csr_we) begin
                case (wr_addr)
                    CSR_MSTATUS: begin
                        mie  <= wr_val[MSTATUS_MIE];
                        mpie <= wr_val[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    mtvec    <= wr_val;
                    CSR_MSCRATCH: mscratch <= wr_val;
                    CSR_MEPC:     mepc     <= wr_val;
                    CSR_MCAUSE:   mcause   <= wr_val;
                    default: ;
                endcase
            end
            if (trap_en) begin
                mepc   <= {now_pc[31:2], 2'b00};
                mcause <= trap_cause;
                mpie   <= mie;
                mie    <= 1'b0;
            end else if (mret_en) begin
                mie  <= mpie;
                mpie <= 1'b1;
            end
        end
    end

    // A write to either half replaces it and suppresses that cycle's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcycle <= '0;
        end else if (csr_we && wr_addr == CSR_MCYCLE) begin
            mcycle[31:0] <= wr_val;
        end else if (csr_we && wr_addr == CSR_MCYCLEH) begin
            mcycle[63:32] <= wr_val;
        end else begin
            mcycle <= mcycle + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            minstret <= '0;
        end else if (csr_we && wr_addr == CSR_MINSTRET) begin
            minstret[31:0] <= wr_val;
        end else if (csr_we && wr_addr == CSR_MINSTRETH) begin
            minstret[63:32] <= wr_val;
        end else if (retire_en) begin
            minstret <= minstret + 64'd1;
        end
    end

    always_comb begin
        mstatus_val               = '0;
        mstatus_val[MSTATUS_MIE]  = mie;
        mstatus_val[MSTATUS_MPIE] = mpie;
    end

    always_comb begin
        rd_val = '0;
        case (rd_addr)
            CSR_MSTATUS:                 rd_val = mstatus_val;
            CSR_MISA:                    rd_val = MISA_VALUE;
            CSR_MTVEC:                   rd_val = mtvec;
            CSR_MSCRATCH:                rd_val = mscratch;
            CSR_MEPC:                    rd_val = mepc;
            CSR_MCAUSE:                  rd_val = mcause;
            CSR_MCYCLE,   CSR_CYCLE:     rd_val = mcycle[31:0];
            CSR_MCYCLEH,  CSR_CYCLEH:    rd_val = mcycle[63:32];
            CSR_MINSTRET, CSR_INSTRET:   rd_val = minstret[31:0];
            CSR_MINSTRETH, CSR_INSTRETH: rd_val = minstret[63:32];
            CSR_MHARTID:                 rd_val = HART_ID;
            default:                     rd_val = '0;
        endcase
    end

    // Bypass forwards only the written value, never the counter increment.
    assign rd_data = (csr_we && rd_addr == wr_addr) ? wr_val : rd_val;

endmodule

// File: rtl/write_back.sv
// Writeback stage of the Kasumi RV32I core: integer register file with
// same-cycle read bypass, commit enable, and the machine-mode CSR file.
module write_back
    import kasumi_csr_pkg::*;
#(
    parameter logic [31:0] HART_ID     = 32'd0,
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stop,
    input  logic [4:0]  in_reg_d,
    input  logic [31:0] in_wb_data,
    input  logic [31:0] in_now_pc,
    input  logic        in_retire,
    input  logic        in_wb_csr,
    input  logic [11:0] in_csr_addr,
    input  logic [31:0] in_csr_data,
    input  logic        in_trap,
    input  logic [31:0] in_trap_cause,
    input  logic        in_mret,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_data,
    output logic [31:0] rs2_data,
    input  logic [11:0] csr_addr,
    output logic [31:0] csr_data,
    output logic [31:0] csr_trap_vec_data,
    output logic [31:0] csr_exception_pc_data
);

    logic [31:0] regs [32];
    logic        ce;
    logic        reg_we;

    assign ce     = in_retire & ~stop & ~rst;
    assign reg_we = ce & ~in_trap & (in_reg_d != 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_we) begin
            regs[in_reg_d] <= in_wb_data;
        end
    end

    // x0 reads zero regardless of what the array or bypass would offer.
    always_comb begin
        if (rs1_addr == 5'd0)
            rs1_data = '0;
        else if (reg_we && rs1_addr == in_reg_d)
            rs1_data = in_wb_data;
        else
            rs1_data = regs[rs1_addr];
    end

    always_comb begin
        if (rs2_addr == 5'd0)
            rs2_data = '0;
        else if (reg_we && rs2_addr == in_reg_d)
            rs2_data = in_wb_data;
        else
            rs2_data = regs[rs2_addr];
    end

    csr_file #(
        .HART_ID     (HART_ID),
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr_file (
        .clk        (clk),
        .rst        (rst),
        .ce         (ce),
        .trap       (in_trap),
        .mret       (in_mret),
        .wb_csr     (in_wb_csr),
        .wr_addr    (in_csr_addr),
        .wr_data    (in_csr_data),
        .now_pc     (in_now_pc),
        .trap_cause (in_trap_cause),
        .rd_addr    (csr_addr),
        .rd_data    (csr_data),
        .trap_vec   (csr_trap_vec_data),
        .epc        (csr_exception_pc_data)
    );

endmodule

// File: tb/tb_write_back.sv
// Scoreboard bench for write_back: directed scenarios plus random traffic
// against an architectural model of the register file and CSRs.
module tb_write_back;

    localparam logic [31:0] HART    = 32'h0000_0003;
    localparam logic [31:0] RST_VEC = 32'h8000_0040;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stop = 1'b0;
    logic [4:0]  in_reg_d = '0;
    logic [31:0] in_wb_data = '0;
    logic [31:0] in_now_pc = '0;
    logic        in_retire = 1'b0;
    logic        in_wb_csr = 1'b0;
    logic [11:0] in_csr_addr = '0;
    logic [31:0] in_csr_data = '0;
    logic        in_trap = 1'b0;
    logic [31:0] in_trap_cause = '0;
    logic        in_mret = 1'b0;
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [11:0] csr_addr = '0;
    logic [31:0] csr_data;
    logic [31:0] csr_trap_vec_data;
    logic [31:0] csr_exception_pc_data;

    always #5 clk = ~clk;

    write_back #(.HART_ID(HART), .RESET_MTVEC(RST_VEC)) dut (
        .clk(clk), .rst(rst), .stop(stop), .in_reg_d(in_reg_d),
        .in_wb_data(in_wb_data), .in_now_pc(in_now_pc), .in_retire(in_retire),
        .in_wb_csr(in_wb_csr), .in_csr_addr(in_csr_addr), .in_csr_data(in_csr_data),
        .in_trap(in_trap), .in_trap_cause(in_trap_cause), .in_mret(in_mret),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
        .rs2_data(rs2_data), .csr_addr(csr_addr), .csr_data(csr_data),
        .csr_trap_vec_data(csr_trap_vec_data),
        .csr_exception_pc_data(csr_exception_pc_data)
    );

    typedef struct packed {
        logic        rst;
        logic        stop;
        logic [4:0]  reg_d;
        logic [31:0] wb_data;
        logic [31:0] pc;
        logic        retire;
        logic        wb_csr;
        logic [11:0] waddr;
        logic [31:0] wdata;
        logic        trap;
        logic [31:0] cause;
        logic        mret;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] raddr;
    } stim_t;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] csr;
        logic [31:0] tvec;
        logic [31:0] epc;
        logic [11:0] raddr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Architectural state of the model.
    logic [31:0] m_x [32];
    logic        m_mie, m_mpie;
    logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cyc, m_ins;

    logic [11:0] addrs [16] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                12'hC02, 12'hC82, 12'hF14, 12'h123};

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic logic [31:0] m_stored(input logic [11:0] a, input logic [31:0] d);
        if (a == 12'h300) return d & 32'h0000_0088;
        if (a == 12'h305 || a == 12'h341) return d & 32'hFFFF_FFFC;
        return d;
    endfunction

    function automatic logic [31:0] m_csr(input logic [11:0] a);
        case (a)
            12'h300:          return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
            12'h301:          return 32'h4000_0100;
            12'h305:          return m_mtvec;
            12'h340:          return m_mscratch;
            12'h341:          return m_mepc;
            12'h342:          return m_mcause;
            12'hB00, 12'hC00: return m_cyc[31:0];
            12'hB80, 12'hC80: return m_cyc[63:32];
            12'hB02, 12'hC02: return m_ins[31:0];
            12'hB82, 12'hC82: return m_ins[63:32];
            12'hF14:          return HART;
            default:          return 32'd0;
        endcase
    endfunction

    function automatic exp_t m_expect(input stim_t s);
        exp_t e;
        bit ce, reg_we, csr_we;
        ce     = s.retire && !s.stop && !s.rst;
        reg_we = ce && !s.trap && s.reg_d != 0;
        csr_we = ce && !s.trap && s.wb_csr && m_writable(s.waddr);
        e.rs1  = (s.rs1 == 0) ? 32'd0 : (reg_we && s.rs1 == s.reg_d) ? s.wb_data : m_x[s.rs1];
        e.rs2  = (s.rs2 == 0) ? 32'd0 : (reg_we && s.rs2 == s.reg_d) ? s.wb_data : m_x[s.rs2];
        e.csr  = (csr_we && s.raddr == s.waddr) ? m_stored(s.waddr, s.wdata) : m_csr(s.raddr);
        e.tvec = m_mtvec;
        e.epc  = m_mepc;
        e.raddr = s.raddr;
        return e;
    endfunction

    task automatic m_update(input stim_t s);
        bit ce, csr_we;
        logic [31:0] v;
        if (s.rst) begin
            foreach (m_x[i]) m_x[i] = 32'd0;
            m_mie = 0; m_mpie = 0; m_mtvec = RST_VEC;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_cyc = 0; m_ins = 0;
            return;
        end
        ce     = s.retire && !s.stop;
        csr_we = ce && !s.trap && s.wb_csr && m_writable(s.waddr);
        v      = m_stored(s.waddr, s.wdata);
        if (csr_we && s.waddr == 12'hB00)      m_cyc = {m_cyc[63:32], v};
        else if (csr_we && s.waddr == 12'hB80) m_cyc = {v, m_cyc[31:0]};
        else                                   m_cyc = m_cyc + 1;
        if (csr_we && s.waddr == 12'hB02)      m_ins = {m_ins[63:32], v};
        else if (csr_we && s.waddr == 12'hB82) m_ins = {v, m_ins[31:0]};
        else if (ce && !s.trap)                m_ins = m_ins + 1;
        if (ce && !s.trap && s.reg_d != 0) m_x[s.reg_d] = s.wb_data;
        if (csr_we) begin
            case (s.waddr)
                12'h300: begin m_mie = v[3]; m_mpie = v[7]; end
                12'h305: m_mtvec = v;
                12'h340: m_mscratch = v;
                12'h341: m_mepc = v;
                12'h342: m_mcause = v;
                default: ;
            endcase
        end
        if (ce && s.trap) begin
            m_mepc = s.pc & 32'hFFFF_FFFC;
            m_mcause = s.cause;
            m_mpie = m_mie;
            m_mie = 0;
        end else if (ce && s.mret) begin
            m_mie = m_mpie;
            m_mpie = 1;
        end
    endtask

    task automatic step(input stim_t s, input bit check);
        @(negedge clk);
        rst = s.rst; stop = s.stop; in_reg_d = s.reg_d; in_wb_data = s.wb_data;
        in_now_pc = s.pc; in_retire = s.retire; in_wb_csr = s.wb_csr;
        in_csr_addr = s.waddr; in_csr_data = s.wdata; in_trap = s.trap;
        in_trap_cause = s.cause; in_mret = s.mret; rs1_addr = s.rs1;
        rs2_addr = s.rs2; csr_addr = s.raddr;
        #1;
        if (check) exp_q.push_back(m_expect(s));
        m_update(s);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        #3;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rs1_data", rs1_data, e.rs1);
            chk("rs2_data", rs2_data, e.rs2);
            chk($sformatf("csr_data[%h]", e.raddr), csr_data, e.csr);
            chk("csr_trap_vec_data", csr_trap_vec_data, e.tvec);
            chk("csr_exception_pc_data", csr_exception_pc_data, e.epc);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        s = '0; s.rst = 1;
        step(s, 0);
        step(s, 1);

        // Read every register and every CSR (including an unlisted one).
        for (int a = 0; a < 32; a++) begin
            s = '0; s.rs1 = 5'(a); s.rs2 = 5'(31 - a); s.raddr = addrs[a % 16];
            step(s, 1);
        end

        // x5 write with same-cycle bypass, then x0 write.
        s = '0; s.retire = 1; s.reg_d = 5; s.wb_data = 32'hDEAD_BEEF; s.rs1 = 5;
        step(s, 1);
        s = '0; s.retire = 1; s.reg_d = 0; s.wb_data = 32'h1234_5678; s.rs1 = 0; s.rs2 = 5;
        step(s, 1);
        s = '0; s.rs1 = 5; s.rs2 = 0;
        step(s, 1);

        // mtvec write with masking, then a stalled write that must not land.
        s = '0; s.retire = 1; s.wb_csr = 1; s.waddr = 12'h305; s.wdata = 32'h0000_1003; s.raddr = 12'h305;
        step(s, 1);
        s.retire = 0; s.wb_csr = 0;
        step(s, 1);
        s = '0; s.stop = 1; s.retire = 1; s.wb_csr = 1; s.waddr = 12'h305; s.wdata = 32'h0000_2000; s.raddr = 12'h305;
        step(s, 1);
        s = '0; s.raddr = 12'h305;
        step(s, 1);

        // MIE=1, then a trap that also requests x7 and mscratch writes.
        s = '0; s.retire = 1; s.wb_csr = 1; s.waddr = 12'h300; s.wdata = 32'h0000_0008; s.raddr = 12'h300;
        step(s, 1);
        s = '0; s.retire = 1; s.trap = 1; s.pc = 32'h0000_0404; s.cause = 32'd11;
        s.reg_d = 7; s.wb_data = 32'h5555_AAAA; s.wb_csr = 1; s.waddr = 12'h340;
        s.wdata = 32'hAAAA_0000; s.mret = 1; s.rs1 = 7; s.raddr = 12'h340;
        step(s, 1);
        s = '0; s.rs1 = 7; s.raddr = 12'h341; step(s, 1);
        s.raddr = 12'h342; step(s, 1);
        s.raddr = 12'h340; step(s, 1);
        s.raddr = 12'h300; step(s, 1);
        s = '0; s.retire = 1; s.mret = 1; s.raddr = 12'h300;
        step(s, 1);
        s = '0; s.raddr = 12'h300; step(s, 1);

        // mcycle carry into mcycleh after a low-half write of all ones.
        s = '0; s.retire = 1; s.wb_csr = 1; s.waddr = 12'hB00; s.wdata = 32'hFFFF_FFFF; s.raddr = 12'hB00;
        step(s, 1);
        s.waddr = 12'hB80; s.wdata = 32'h0; s.raddr = 12'hB80;
        step(s, 1);
        s = '0; s.raddr = 12'hB00; step(s, 1);
        s.raddr = 12'hB80; step(s, 1);
        s.raddr = 12'hB00; step(s, 1);
        s.raddr = 12'hC80; step(s, 1);

        // Three retirements separated by 4-cycle stalls.
        s = '0; s.rst = 1; step(s, 1);
        for (int k = 0; k < 3; k++) begin
            s = '0; s.retire = 1; s.raddr = 12'hB02; s.reg_d = 5'(9 + k); s.wb_data = 32'(k + 100);
            if (k < 2) begin
                step(s, 1);
                s.stop = 1;
                for (int j = 0; j < 4; j++) step(s, 1);
                s.stop = 0;
            end else begin
                step(s, 1);
            end
        end
        s = '0; s.raddr = 12'hB02; s.rs1 = 9; s.rs2 = 11; step(s, 1);
        s.raddr = 12'hB00; step(s, 1);
        s.raddr = 12'hC02; step(s, 1);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            s = '0;
            s.rst    = ($urandom_range(0, 99) == 0);
            s.stop   = ($urandom_range(0, 3) == 0);
            s.retire = ($urandom_range(0, 4) != 0);
            s.reg_d  = 5'($urandom);
            s.wb_data = $urandom;
            s.pc     = $urandom;
            s.wb_csr = ($urandom_range(0, 2) == 0);
            s.waddr  = addrs[$urandom_range(0, 15)];
            s.wdata  = $urandom;
            s.trap   = ($urandom_range(0, 7) == 0);
            s.cause  = $urandom;
            s.mret   = ($urandom_range(0, 7) == 0);
            s.rs1    = ($urandom_range(0, 2) == 0) ? s.reg_d : 5'($urandom);
            s.rs2    = 5'($urandom);
            s.raddr  = ($urandom_range(0, 2) == 0) ? s.waddr : addrs[$urandom_range(0, 15)];
            step(s, 1);
        end

        s = '0;
        step(s, 0);
        @(negedge clk);
        #5;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
